// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial two's-complement subtractor (diff = a - b), LSB
//               first, with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int            CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic             r_amsb;
  logic             r_bmsb;
  logic             r_bflop;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_ovf;

  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_sa_sh;
  logic [WIDTH-1:0] w_sb_sh;

  // Full-subtractor cell
  assign w_ai   = r_sa[0];
  assign w_bi   = r_sb[0];
  assign w_d    = w_ai ^ w_bi ^ r_bflop;
  assign w_bout = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_bflop);
  assign w_last = (r_cnt == C_LAST);
  // The last cell output is the sign bit of the result.
  assign w_ovf  = (r_amsb != r_bmsb) && (w_d != r_amsb);

  generate
    if (WIDTH == 1) begin : g_one
      assign w_res_next = w_d;
      assign w_sa_sh    = 1'b0;
      assign w_sb_sh    = 1'b0;
    end else begin : g_multi
      // Partial result; the final bit is merged straight into diff.
      logic [WIDTH-2:0] r_res;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_res <= '0;
        end else if (r_state == S_RUN) begin
          r_res <= w_res_next[WIDTH-1:1];
        end
      end

      assign w_res_next = {w_d, r_res};
      assign w_sa_sh    = {1'b0, r_sa[WIDTH-1:1]};
      assign w_sb_sh    = {1'b0, r_sb[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_amsb   <= 1'b0;
      r_bmsb   <= 1'b0;
      r_bflop  <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_amsb  <= a[WIDTH-1];
            r_bmsb  <= b[WIDTH-1];
            r_bflop <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_sa    <= w_sa_sh;
          r_sb    <= w_sb_sh;
          r_bflop <= w_bout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff   <= w_res_next;
            r_borrow <= w_bout;
            r_ovf    <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign diff     = r_diff;
  assign borrow   = r_borrow;
  assign overflow = r_ovf;

endmodule
`default_nettype wire
